// File: rtl/bp_nbf_pkg.sv
`default_nettype none
// ============================================================================
//  Package  : bp_nbf_pkg
//  Purpose  : Shared NBF command layout and constants for the AXI-Lite receiver
//  Revision : 1.0
// ============================================================================
package bp_nbf_pkg;

    localparam int c_nbf_opcode_width = 8;
    localparam int c_nbf_addr_width   = 64;
    localparam int c_nbf_data_width   = 64;
    localparam int c_nbf_width        = c_nbf_opcode_width + c_nbf_addr_width + c_nbf_data_width;
    localparam int c_nbf_flit_width   = 32;
    localparam int c_nbf_flit_count   = 5;
    localparam int c_nbf_cnt_width    = 3;
    localparam int c_cmd_cnt_width    = 31;

    localparam logic [c_nbf_opcode_width-1:0] c_nbf_opcode_finish = 8'hFF;

    localparam logic [1:0] c_axi_resp_okay   = 2'b00;
    localparam logic [1:0] c_axi_resp_slverr = 2'b10;

    typedef struct packed {
        logic [c_nbf_opcode_width-1:0] opcode;
        logic [c_nbf_addr_width-1:0]   addr;
        logic [c_nbf_data_width-1:0]   data;
    } bp_nbf_s;

    typedef enum logic [0:0] {
        e_idle = 1'b0,
        e_resp = 1'b1
    } rd_state_e;

    function automatic logic [c_cmd_cnt_width-1:0] sat_inc(input logic [c_cmd_cnt_width-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bp_nbf_axil_receiver.sv
`default_nettype none
// ============================================================================
//  Module   : bp_nbf_axil_receiver
//  Purpose  : AXI-Lite slave assembling five 32-bit writes into one NBF command
//  Revision : 1.0
// ============================================================================
module bp_nbf_axil_receiver
    import bp_nbf_pkg::*;
#(
    parameter int                           S_AXIL_ADDR_WIDTH = 64,
    parameter int                           S_AXIL_DATA_WIDTH = 32,
    parameter logic [S_AXIL_ADDR_WIDTH-1:0] nbf_host_addr_p   = '0
) (
    input  logic                             s_axil_aclk,
    input  logic                             s_axil_aresetn,

    input  logic [S_AXIL_ADDR_WIDTH-1:0]     s_axil_awaddr,
    input  logic                             s_axil_awvalid,
    output logic                             s_axil_awready,
    input  logic [2:0]                       s_axil_awprot,

    input  logic [S_AXIL_DATA_WIDTH-1:0]     s_axil_wdata,
    input  logic                             s_axil_wvalid,
    output logic                             s_axil_wready,
    input  logic [S_AXIL_DATA_WIDTH/8-1:0]   s_axil_wstrb,

    output logic                             s_axil_bvalid,
    input  logic                             s_axil_bready,
    output logic [1:0]                       s_axil_bresp,

    input  logic [S_AXIL_ADDR_WIDTH-1:0]     s_axil_araddr,
    input  logic                             s_axil_arvalid,
    output logic                             s_axil_arready,
    input  logic [2:0]                       s_axil_arprot,

    output logic [S_AXIL_DATA_WIDTH-1:0]     s_axil_rdata,
    output logic                             s_axil_rvalid,
    input  logic                             s_axil_rready,
    output logic [1:0]                       s_axil_rresp,

    output logic [c_nbf_width-1:0]           nbf_o,
    output logic                             nbf_v_o,
    input  logic                             nbf_ready_i,
    output logic                             done_o
);

    localparam int c_pkt_width = c_nbf_addr_width + c_nbf_data_width;
    localparam logic [c_nbf_cnt_width-1:0] c_last_flit = c_nbf_cnt_width'(c_nbf_flit_count - 1);

    logic                             aw_full_q, aw_full_d;
    logic [S_AXIL_ADDR_WIDTH-1:0]     awaddr_q, awaddr_d;
    logic                             w_full_q, w_full_d;
    logic [S_AXIL_DATA_WIDTH-1:0]     wdata_q, wdata_d;
    logic [S_AXIL_DATA_WIDTH/8-1:0]   wstrb_q, wstrb_d;
    logic                             bvalid_q, bvalid_d;
    logic [1:0]                       bresp_q, bresp_d;
    logic [c_nbf_cnt_width-1:0]       word_cnt_q, word_cnt_d;
    logic [c_pkt_width-1:0]           pkt_q, pkt_d;
    bp_nbf_s                          nbf_q, nbf_d;
    logic                             nbf_v_q, nbf_v_d;
    logic                             done_q, done_d;
    logic [c_cmd_cnt_width-1:0]       cmd_cnt_q, cmd_cnt_d;

    rd_state_e                        rd_state_q;
    logic [S_AXIL_DATA_WIDTH-1:0]     rdata_q;
    logic [1:0]                       rresp_q;

    logic aw_hs, w_hs, nbf_hs, addr_hit, commit;
    logic unused_prot;

    // Ready is forced low while reset is asserted, not just after the first edge.
    assign s_axil_awready = s_axil_aresetn & ~aw_full_q;
    assign s_axil_wready  = s_axil_aresetn & ~w_full_q;
    assign s_axil_arready = s_axil_aresetn & (rd_state_q == e_idle);

    assign aw_hs    = s_axil_awvalid & s_axil_awready;
    assign w_hs     = s_axil_wvalid  & s_axil_wready;
    assign nbf_hs   = nbf_v_q & nbf_ready_i;
    assign addr_hit = (awaddr_q == nbf_host_addr_p) & (&wstrb_q);
    // A hit must not overwrite the packet while the previous command is still pending.
    assign commit   = aw_full_q & w_full_q & (~bvalid_q | s_axil_bready) & ~(addr_hit & nbf_v_q);

    assign unused_prot = ^{s_axil_awprot, s_axil_arprot};

    always_comb begin
        aw_full_d  = aw_full_q;
        awaddr_d   = awaddr_q;
        w_full_d   = w_full_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        bvalid_d   = bvalid_q;
        bresp_d    = bresp_q;
        word_cnt_d = word_cnt_q;
        pkt_d      = pkt_q;
        nbf_d      = nbf_q;
        nbf_v_d    = nbf_v_q;
        done_d     = done_q;
        cmd_cnt_d  = cmd_cnt_q;

        if (aw_hs) begin
            aw_full_d = 1'b1;
            awaddr_d  = s_axil_awaddr;
        end
        if (w_hs) begin
            w_full_d = 1'b1;
            wdata_d  = s_axil_wdata;
            wstrb_d  = s_axil_wstrb;
        end

        if (commit) begin
            aw_full_d = 1'b0;
            w_full_d  = 1'b0;
            bvalid_d  = 1'b1;
            if (addr_hit) begin
                bresp_d = c_axi_resp_okay;
                if (word_cnt_q == c_last_flit) begin
                    nbf_d      = {wdata_q[c_nbf_opcode_width-1:0], pkt_q};
                    nbf_v_d    = 1'b1;
                    word_cnt_d = '0;
                end else begin
                    pkt_d[{word_cnt_q[1:0], 5'd0} +: c_nbf_flit_width] = wdata_q[c_nbf_flit_width-1:0];
                    word_cnt_d = word_cnt_q + 1'b1;
                end
            end else begin
                bresp_d = c_axi_resp_slverr;
            end
        end else if (s_axil_bready) begin
            bvalid_d = 1'b0;
        end

        if (nbf_hs) begin
            nbf_v_d   = 1'b0;
            cmd_cnt_d = sat_inc(cmd_cnt_q);
            if (nbf_q.opcode == c_nbf_opcode_finish) begin
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge s_axil_aclk or negedge s_axil_aresetn) begin
        if (!s_axil_aresetn) begin
            aw_full_q  <= 1'b0;
            awaddr_q   <= '0;
            w_full_q   <= 1'b0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            bvalid_q   <= 1'b0;
            bresp_q    <= '0;
            word_cnt_q <= '0;
            pkt_q      <= '0;
            nbf_q      <= '0;
            nbf_v_q    <= 1'b0;
            done_q     <= 1'b0;
            cmd_cnt_q  <= '0;
        end else begin
            aw_full_q  <= aw_full_d;
            awaddr_q   <= awaddr_d;
            w_full_q   <= w_full_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            word_cnt_q <= word_cnt_d;
            pkt_q      <= pkt_d;
            nbf_q      <= nbf_d;
            nbf_v_q    <= nbf_v_d;
            done_q     <= done_d;
            cmd_cnt_q  <= cmd_cnt_d;
        end
    end

    // Status is snapshotted at the AR handshake and held for the whole R phase.
    always_ff @(posedge s_axil_aclk or negedge s_axil_aresetn) begin
        if (!s_axil_aresetn) begin
            rd_state_q <= e_idle;
            rdata_q    <= '0;
            rresp_q    <= '0;
        end else begin
            case (rd_state_q)
                e_idle: begin
                    if (s_axil_arvalid) begin
                        rd_state_q <= e_resp;
                        if (s_axil_araddr == nbf_host_addr_p) begin
                            rdata_q <= S_AXIL_DATA_WIDTH'({done_q, cmd_cnt_q});
                            rresp_q <= c_axi_resp_okay;
                        end else begin
                            rdata_q <= '0;
                            rresp_q <= c_axi_resp_slverr;
                        end
                    end
                end
                e_resp: begin
                    if (s_axil_rready) begin
                        rd_state_q <= e_idle;
                    end
                end
                default: rd_state_q <= e_idle;
            endcase
        end
    end

    assign s_axil_bvalid = bvalid_q;
    assign s_axil_bresp  = bresp_q;
    assign s_axil_rvalid = (rd_state_q == e_resp);
    assign s_axil_rdata  = rdata_q;
    assign s_axil_rresp  = rresp_q;
    assign nbf_o         = nbf_q;
    assign nbf_v_o       = nbf_v_q;
    assign done_o        = done_q;

endmodule
`default_nettype wire

// File: tb/tb_bp_nbf_axil_receiver.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bp_nbf_axil_receiver
//  Purpose  : Scoreboard bench for the NBF AXI-Lite receiver
//  Revision : 1.0
// ============================================================================
module tb_bp_nbf_axil_receiver;

    localparam logic [63:0] HOST = 64'h0;
    localparam logic [63:0] MISS = HOST + 64'd4;

    logic         clk;
    logic         rst_n;
    logic [63:0]  awaddr;
    logic         awvalid, awready;
    logic [2:0]   awprot;
    logic [31:0]  wdata;
    logic         wvalid, wready;
    logic [3:0]   wstrb;
    logic         bvalid, bready;
    logic [1:0]   bresp;
    logic [63:0]  araddr;
    logic         arvalid, arready;
    logic [2:0]   arprot;
    logic [31:0]  rdata;
    logic         rvalid, rready;
    logic [1:0]   rresp;
    logic [135:0] nbf_o;
    logic         nbf_v, nbf_ready;
    logic         done;

    int checks = 0;
    int errors = 0;

    logic [1:0]   exp_b_q[$];
    logic [135:0] exp_pkt_q[$];
    logic [135:0] obs_pkt_q[$];
    logic [31:0]  m_words[5];
    int           m_k;
    int           m_sent;
    bit           m_done;

    bp_nbf_axil_receiver #(
        .S_AXIL_ADDR_WIDTH (64),
        .S_AXIL_DATA_WIDTH (32),
        .nbf_host_addr_p   (HOST)
    ) dut (
        .s_axil_aclk    (clk),
        .s_axil_aresetn (rst_n),
        .s_axil_awaddr  (awaddr),
        .s_axil_awvalid (awvalid),
        .s_axil_awready (awready),
        .s_axil_awprot  (awprot),
        .s_axil_wdata   (wdata),
        .s_axil_wvalid  (wvalid),
        .s_axil_wready  (wready),
        .s_axil_wstrb   (wstrb),
        .s_axil_bvalid  (bvalid),
        .s_axil_bready  (bready),
        .s_axil_bresp   (bresp),
        .s_axil_araddr  (araddr),
        .s_axil_arvalid (arvalid),
        .s_axil_arready (arready),
        .s_axil_arprot  (arprot),
        .s_axil_rdata   (rdata),
        .s_axil_rvalid  (rvalid),
        .s_axil_rready  (rready),
        .s_axil_rresp   (rresp),
        .nbf_o          (nbf_o),
        .nbf_v_o        (nbf_v),
        .nbf_ready_i    (nbf_ready),
        .done_o         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Records every NBF handshake; the edge after this negedge completes it.
    always @(negedge clk) begin
        if (rst_n && nbf_v && nbf_ready) obs_pkt_q.push_back(nbf_o);
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic model_clear();
        exp_b_q.delete();
        exp_pkt_q.delete();
        obs_pkt_q.delete();
        m_k = 0;
        m_sent = 0;
        m_done = 1'b0;
    endtask

    task automatic model_write(input logic [63:0] a, input logic [31:0] d, input logic [3:0] s);
        if (a == HOST && s == 4'hF) begin
            exp_b_q.push_back(2'b00);
            m_words[m_k] = d;
            if (m_k == 4) begin
                exp_pkt_q.push_back({d[7:0], m_words[3], m_words[2], m_words[1], m_words[0]});
                m_sent++;
                if (d[7:0] == 8'hFF) m_done = 1'b1;
                m_k = 0;
            end else begin
                m_k++;
            end
        end else begin
            exp_b_q.push_back(2'b10);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        bready = 1'b1; rready = 1'b1; nbf_ready = 1'b1;
        model_clear();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic axil_send(input logic [63:0] a, input logic [31:0] d, input logic [3:0] s, input int w_lead);
        bit aw_done, w_done, hs_aw, hs_w;
        aw_done = 1'b0; w_done = 1'b0;
        awaddr = a; wdata = d; wstrb = s;
        for (int cyc = 0; cyc < 200 && !(aw_done && w_done); cyc++) begin
            awvalid = !aw_done && (cyc >= w_lead);
            wvalid  = !w_done;
            @(negedge clk);
            hs_aw = awvalid && awready;
            hs_w  = wvalid && wready;
            @(posedge clk); #1;
            if (hs_aw) aw_done = 1'b1;
            if (hs_w)  w_done  = 1'b1;
        end
        awvalid = 1'b0; wvalid = 1'b0;
        if (!(aw_done && w_done)) begin
            checks++; errors++;
            $display("FAIL send_timeout aw_done=%0d w_done=%0d required both 1", aw_done, w_done);
        end
    endtask

    task automatic axil_wait_b(output logic [1:0] resp, output int lat);
        bit found;
        found = 1'b0; lat = 0; resp = 2'bxx;
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge clk);
            lat++;
            if (bvalid) begin
                resp = bresp;
                found = 1'b1;
            end
        end
        if (found) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic do_write(input logic [63:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int lead, output logic [1:0] resp, output int lat);
        model_write(a, d, s);
        axil_send(a, d, s, lead);
        axil_wait_b(resp, lat);
    endtask

    task automatic axil_read(input logic [63:0] a, output logic [31:0] d, output logic [1:0] r, output bit ok);
        bit hs;
        ok = 1'b0; hs = 1'b0; d = 32'hxxxxxxxx; r = 2'bxx;
        araddr = a; arvalid = 1'b1;
        for (int i = 0; i < 50 && !hs; i++) begin
            @(negedge clk);
            hs = arready;
            @(posedge clk); #1;
        end
        arvalid = 1'b0;
        if (hs) begin
            for (int i = 0; i < 50 && !ok; i++) begin
                @(negedge clk);
                if (rvalid) begin
                    d = rdata; r = rresp; ok = 1'b1;
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_pkt(output logic [135:0] p, output bit ok);
        ok = 1'b0; p = '0;
        for (int i = 0; i < 50 && !ok; i++) begin
            if (obs_pkt_q.size() > 0) begin
                p = obs_pkt_q.pop_front();
                ok = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
    endtask

    task automatic send_packet(input logic [31:0] w[5], input string tag);
        logic [1:0] resp, exp;
        int lat;
        logic [135:0] p, e;
        bit ok;
        for (int i = 0; i < 5; i++) begin
            do_write(HOST, w[i], 4'hF, 0, resp, lat);
            exp = exp_b_q.pop_front();
            checks++;
            if (resp !== exp) begin
                errors++;
                $display("FAIL %s_bresp[%0d] got %b required %b", tag, i, resp, exp);
            end
        end
        wait_pkt(p, ok);
        e = (exp_pkt_q.size() > 0) ? exp_pkt_q.pop_front() : '1;
        checks++;
        if (!ok || p !== e) begin
            errors++;
            $display("FAIL %s_packet got %h (seen=%0d) required %h", tag, p, ok, e);
        end
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic [1:0] r;
        bit ok;
        rst_n = 1'b0;
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        awaddr = '0; wdata = '0; wstrb = '0; araddr = '0;
        awprot = 3'b000; arprot = 3'b000;
        bready = 1'b1; rready = 1'b1; nbf_ready = 1'b1;
        model_clear();
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({awready, wready, arready} !== 3'b000) begin
            errors++;
            $display("FAIL reset_ready got %b required 000", {awready, wready, arready});
        end
        checks++;
        if ({bvalid, rvalid, nbf_v, done} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_valids got %b required 0000", {bvalid, rvalid, nbf_v, done});
        end
        checks++;
        if (bresp !== 2'b00 || rresp !== 2'b00 || rdata !== 32'h0 || nbf_o !== 136'h0) begin
            errors++;
            $display("FAIL reset_data bresp=%b rresp=%b rdata=%h nbf=%h required all 0", bresp, rresp, rdata, nbf_o);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({awready, wready, arready} !== 3'b111) begin
            errors++;
            $display("FAIL post_reset_ready got %b required 111", {awready, wready, arready});
        end
        axil_read(HOST, d, r, ok);
        checks++;
        if (!ok || d !== {m_done, 31'(m_sent)} || r !== 2'b00) begin
            errors++;
            $display("FAIL reset_status_read got %h/%b required %h/00", d, r, {m_done, 31'(m_sent)});
        end
    endtask

    task automatic test_basic_packet();
        logic [31:0] w[5];
        logic [1:0] resp, exp;
        int lat;
        logic [135:0] p, e;
        bit ok;
        w = '{32'h89ABCDEF, 32'h01234567, 32'h00001000, 32'h0, 32'h00000003};
        for (int i = 0; i < 5; i++) begin
            do_write(HOST, w[i], 4'hF, 0, resp, lat);
            exp = exp_b_q.pop_front();
            checks++;
            if (resp !== exp) begin
                errors++;
                $display("FAIL basic_bresp[%0d] got %b required %b", i, resp, exp);
            end
            checks++;
            if (lat != 2) begin
                errors++;
                $display("FAIL basic_b_latency[%0d] got %0d required 2", i, lat);
            end
        end
        wait_pkt(p, ok);
        e = (exp_pkt_q.size() > 0) ? exp_pkt_q.pop_front() : '1;
        checks++;
        if (!ok || p !== e) begin
            errors++;
            $display("FAIL basic_packet got %h (seen=%0d) required %h", p, ok, e);
        end
        checks++;
        if (p !== {8'h03, 64'h1000, 64'h0123456789ABCDEF}) begin
            errors++;
            $display("FAIL basic_packet_const got %h required %h", p, {8'h03, 64'h1000, 64'h0123456789ABCDEF});
        end
    endtask

    task automatic test_w_leads_aw();
        logic [31:0] w[5];
        logic [1:0] resp, exp;
        int lat;
        logic [135:0] p, e;
        bit ok;
        w = '{32'h89ABCDEF, 32'h01234567, 32'h00001000, 32'h0, 32'h00000003};
        for (int i = 0; i < 5; i++) begin
            do_write(HOST, w[i], 4'hF, 3, resp, lat);
            exp = exp_b_q.pop_front();
            checks++;
            if (resp !== exp || lat != 2) begin
                errors++;
                $display("FAIL wlead_b[%0d] got resp %b lat %0d required %b lat 2", i, resp, lat, exp);
            end
        end
        wait_pkt(p, ok);
        e = (exp_pkt_q.size() > 0) ? exp_pkt_q.pop_front() : '1;
        checks++;
        if (!ok || p !== e) begin
            errors++;
            $display("FAIL wlead_packet got %h (seen=%0d) required %h", p, ok, e);
        end
    endtask

    task automatic test_miss();
        logic [63:0] a[8];
        logic [31:0] d[8];
        logic [3:0]  s[8];
        logic [1:0] resp, exp;
        int lat;
        logic [135:0] p, e;
        bit ok;
        a = '{MISS, HOST, HOST, HOST, MISS, HOST, HOST, HOST};
        s = '{4'hF, 4'h7, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF};
        d = '{32'hDEAD0001, 32'hDEAD0002, 32'h11112222, 32'h33334444, 32'hDEAD0003,
              32'h80000000, 32'h00000001, 32'hABCDEF42};
        for (int i = 0; i < 8; i++) begin
            do_write(a[i], d[i], s[i], i % 2, resp, lat);
            exp = exp_b_q.pop_front();
            checks++;
            if (resp !== exp) begin
                errors++;
                $display("FAIL miss_bresp[%0d] got %b required %b", i, resp, exp);
            end
        end
        wait_pkt(p, ok);
        e = (exp_pkt_q.size() > 0) ? exp_pkt_q.pop_front() : '1;
        checks++;
        if (!ok || p !== e) begin
            errors++;
            $display("FAIL miss_packet got %h (seen=%0d) required %h", p, ok, e);
        end
    endtask

    task automatic test_stall();
        logic [31:0] w1[5], w2[5];
        logic [1:0] resp, exp;
        int lat;
        logic [135:0] p, e;
        bit ok;
        w1 = '{32'hCAFE0000, 32'hCAFE0001, 32'h00002000, 32'h00000001, 32'h00000011};
        w2 = '{32'hBEEF0000, 32'hBEEF0001, 32'h00003000, 32'h00000002, 32'h00000022};
        nbf_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            do_write(HOST, w1[i], 4'hF, 0, resp, lat);
            exp = exp_b_q.pop_front();
            checks++;
            if (resp !== exp) begin
                errors++;
                $display("FAIL stall_p1_bresp[%0d] got %b required %b", i, resp, exp);
            end
        end
        do_write(MISS, 32'h5A5A5A5A, 4'hF, 0, resp, lat);
        exp = exp_b_q.pop_front();
        checks++;
        if (resp !== exp || lat != 2) begin
            errors++;
            $display("FAIL stall_miss_proceeds got resp %b lat %0d required %b lat 2", resp, lat, exp);
        end
        model_write(HOST, w2[0], 4'hF);
        axil_send(HOST, w2[0], 4'hF, 0);
        e = (exp_pkt_q.size() > 0) ? exp_pkt_q[0] : '1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            checks++;
            if (bvalid !== 1'b0 || nbf_v !== 1'b1 || nbf_o !== e) begin
                errors++;
                $display("FAIL stall_hold[%0d] bvalid=%b nbf_v=%b nbf=%h required 0/1/%h", c, bvalid, nbf_v, nbf_o, e);
            end
        end
        @(posedge clk); #1;
        nbf_ready = 1'b1;
        axil_wait_b(resp, lat);
        exp = exp_b_q.pop_front();
        checks++;
        if (resp !== exp) begin
            errors++;
            $display("FAIL stall_released_bresp got %b required %b", resp, exp);
        end
        wait_pkt(p, ok);
        e = (exp_pkt_q.size() > 0) ? exp_pkt_q.pop_front() : '1;
        checks++;
        if (!ok || p !== e) begin
            errors++;
            $display("FAIL stall_packet1 got %h (seen=%0d) required %h", p, ok, e);
        end
        for (int i = 1; i < 5; i++) begin
            do_write(HOST, w2[i], 4'hF, 0, resp, lat);
            exp = exp_b_q.pop_front();
            checks++;
            if (resp !== exp) begin
                errors++;
                $display("FAIL stall_p2_bresp[%0d] got %b required %b", i, resp, exp);
            end
        end
        wait_pkt(p, ok);
        e = (exp_pkt_q.size() > 0) ? exp_pkt_q.pop_front() : '1;
        checks++;
        if (!ok || p !== e) begin
            errors++;
            $display("FAIL stall_packet2 got %h (seen=%0d) required %h", p, ok, e);
        end
    endtask

    task automatic test_finish();
        logic [31:0] wa[5], wf[5];
        logic [31:0] d;
        logic [1:0] r;
        bit ok;
        wa = '{32'h00000010, 32'h0, 32'h00004000, 32'h0, 32'h00000003};
        wf = '{32'h0, 32'h0, 32'h0, 32'h0, 32'hABCDEFFF};
        do_reset();
        send_packet(wa, "fin_pre");
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL fin_done_early got %b required 0", done);
        end
        send_packet(wf, "fin_ff");
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL fin_done got %b required 1", done);
        end
        axil_read(HOST, d, r, ok);
        checks++;
        if (!ok || d !== {m_done, 31'(m_sent)} || d !== 32'h80000002 || r !== 2'b00) begin
            errors++;
            $display("FAIL fin_status got %h/%b required 80000002/00", d, r);
        end
        axil_read(MISS, d, r, ok);
        checks++;
        if (!ok || d !== 32'h0 || r !== 2'b10) begin
            errors++;
            $display("FAIL fin_read_miss got %h/%b required 00000000/10", d, r);
        end
        send_packet(wa, "fin_post");
        axil_read(HOST, d, r, ok);
        checks++;
        if (!ok || d !== {m_done, 31'(m_sent)} || r !== 2'b00) begin
            errors++;
            $display("FAIL fin_status_sticky got %h/%b required %h/00", d, r, {m_done, 31'(m_sent)});
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] w[5];
        logic [1:0] resp, exp;
        int lat;
        w = '{32'h77770000, 32'h77770001, 32'h00005000, 32'h00000003, 32'h00000044};
        for (int i = 0; i < 3; i++) begin
            do_write(HOST, w[i], 4'hF, 0, resp, lat);
            exp = exp_b_q.pop_front();
            checks++;
            if (resp !== exp) begin
                errors++;
                $display("FAIL rmid_bresp[%0d] got %b required %b", i, resp, exp);
            end
        end
        bready = 1'b0; rready = 1'b0;
        axil_send(HOST, 32'hFFFFFFFF, 4'hF, 0);
        araddr = HOST; arvalid = 1'b1;
        repeat (3) @(posedge clk);
        #1 arvalid = 1'b0;
        @(negedge clk);
        checks++;
        if (bvalid !== 1'b1 || rvalid !== 1'b1) begin
            errors++;
            $display("FAIL rmid_pre got bvalid=%b rvalid=%b required 1/1", bvalid, rvalid);
        end
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if ({awready, wready, arready, bvalid, rvalid, nbf_v, done} !== 7'b0 ||
            bresp !== 2'b00 || rresp !== 2'b00 || rdata !== 32'h0 || nbf_o !== 136'h0) begin
            errors++;
            $display("FAIL rmid_async_clear flags=%b bresp=%b rresp=%b rdata=%h nbf=%h required all 0",
                     {awready, wready, arready, bvalid, rvalid, nbf_v, done}, bresp, rresp, rdata, nbf_o);
        end
        bready = 1'b1; rready = 1'b1;
        model_clear();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        send_packet(w, "rmid_fresh");
    endtask

    initial begin
        test_reset();
        test_basic_packet();
        test_w_leads_aw();
        test_miss();
        test_stall();
        test_finish();
        test_reset_mid();
        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bp_nbf_axil_receiver.md
BP_NBF_AXIL_RECEIVER -- requirements
Module: bp_nbf_axil_receiver
Interface
REQ-001 Parameters SHALL be S_AXIL_ADDR_WIDTH, default 64, address width.
REQ-002 Parameters SHALL include S_AXIL_DATA_WIDTH, default 32, data width; only 32 is legal.
REQ-003 Parameters SHALL include nbf_host_addr_p, default 64'h0, the sole accepted write/read address.
REQ-004 s_axil_aclk  in  1  single clock; all state on its rising edge.
REQ-005 s_axil_aresetn  in  1  reset, asynchronous, active-low.
REQ-006 s_axil_awaddr/awvalid/awready/awprot  in/in/out/in  ADDR/1/1/3  write address; awprot ignored.
REQ-007 s_axil_wdata/wvalid/wready/wstrb  in/in/out/in  32/1/1/4  write data.
REQ-008 s_axil_bvalid/bready/bresp  out/in/out  1/1/2  write response.
REQ-009 s_axil_araddr/arvalid/arready/arprot  in/in/out/in  ADDR/1/1/3  read address; arprot ignored.
REQ-010 s_axil_rdata/rvalid/rready/rresp  out/out/in/out  32/1/1/2  read data.
REQ-011 nbf_o  out  136  assembled NBF command {opcode[7:0], addr[63:0], data[63:0]}.
REQ-012 nbf_v_o / nbf_ready_i  out/in  1/1  ready-valid handshake for nbf_o.
REQ-013 done_o  out  1  sticky; finish command (opcode 8'hFF) has been emitted.
Function
REQ-014 awready SHALL equal ~aw_full, wready ~w_full; AW and W accepted independently into one-entry holding registers, any order.
REQ-015 A word SHALL commit in a cycle with aw_full & w_full & (~bvalid | bready) & ~(addr-hit & nbf_v_o); commit clears both holding flags.
REQ-016 Address hit = awaddr==nbf_host_addr_p and wstrb==4'hF; miss SHALL discard the word, bresp=2'b10 (SLVERR), word counter unchanged.
REQ-017 Hit SHALL store wdata into flit slot k (k = word counter, 0..4), bits [32k+31:32k] of a 160-bit zero-extended packet, bresp=2'b00.
REQ-018 Flit order: k0 data[31:0], k1 data[63:32], k2 addr[31:0], k3 addr[63:32], k4 wdata[7:0]=opcode, wdata[31:8] ignored.
REQ-019 bvalid SHALL rise the cycle after commit and hold with stable bresp until bready.
REQ-020 Word counter SHALL wrap 4->0 on the k4 commit, and nbf_v_o SHALL rise the following cycle.
REQ-021 nbf_o/nbf_v_o SHALL hold stable until nbf_ready_i; hit commits stall meanwhile, miss commits proceed.
REQ-022 done_o SHALL set on the nbf_o handshake with opcode 8'hFF; later commands continue to be received and emitted.
REQ-023 Read FSM e_idle (arready=1) -> e_resp on ar handshake; e_resp (rvalid=1) -> e_idle on rready; fully independent of writes.
REQ-024 Read hit SHALL return rdata={done_o, emitted-command count[30:0] saturating at 2^31-1}, rresp=2'b00; miss rdata=0, rresp=2'b10.
REQ-025 Simultaneous commit and B handshake SHALL be legal; back-to-back words sustain one commit per two cycles minimum.
Reset
REQ-026 Reset low SHALL immediately clear aw_full, w_full, bvalid, rvalid, nbf_v_o, done_o, word counter, command count; read FSM to e_idle.
REQ-027 During reset awready=wready=arready=0; outputs bresp, rresp, rdata, nbf_o = 0; partial packet discarded on mid-operation reset.
Structure
REQ-028 bp_nbf_pkg SHALL hold bp_nbf_s typedef, opcode/addr/data widths, flit count 5, and finish opcode 8'hFF.
REQ-029 No sub-module; holding registers, counters, FSM inline with asynchronous reset (library counters reset synchronously).
Verification
REQ-030 Five hit writes 0x89ABCDEF,0x01234567,0x00001000,0x0,0x00000003 -> nbf_o={8'h03,64'h1000,64'h0123456789ABCDEF}, five OKAY.
REQ-031 W precedes AW by 3 cycles on every word -> identical packet; bvalid exactly one cycle after each commit.
REQ-032 Write to nbf_host_addr_p+4, or wstrb=4'h7 -> SLVERR, counter unchanged, next hit lands in slot 0.
REQ-033 nbf_ready_i=0 for 20 cycles after packet -> nbf_o stable, next-packet word-0 B withheld until handshake.
REQ-034 Finish packet opcode 8'hFF then read -> done_o=1, rdata=0x80000002 after two commands emitted.
REQ-035 aresetn low after word 2 committed -> all outputs 0 at once; fresh five-word sequence yields correct packet.
